// File: rtl/fp_mul_result_stage_if.sv
// Handshake bundle between the float multiplier result stage and its producer/consumer.
// The master drives operands and out_ready; the slave returns status and the buffered result.
interface fp_mul_result_stage_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      A;
    logic [31:0]      B;
    logic [31:0]      Product;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      Result;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] OpCount;

    modport master (
        output in_valid, A, B, Product, out_ready,
        input  in_ready, out_valid, Result, Flags, OpCount
    );

    modport slave (
        input  in_valid, A, B, Product, out_ready,
        output in_ready, out_valid, Result, Flags, OpCount
    );
endinterface

// File: rtl/fp_mul_result_stage.sv
// IEEE-754 single special-case fix-up on the raw multiplier product, followed by a
// small valid/ready FIFO holding {flags, result} entries.
module fp_mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_mul_result_stage_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = $clog2(DEPTH + 1);

    // ---------------- operand classification ----------------
    logic [1:0]  w_is_nan;
    logic [1:0]  w_is_inf;
    logic [1:0]  w_is_zero;
    logic [7:0]  w_exp_adj [2];
    logic [31:0] w_ops [2];

    assign w_ops[0] = bus.A;
    assign w_ops[1] = bus.B;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opclass
            assign w_is_nan[gi]  = (w_ops[gi][30:23] == 8'hFF) && (w_ops[gi][22:0] != 23'h0);
            assign w_is_inf[gi]  = (w_ops[gi][30:23] == 8'hFF) && (w_ops[gi][22:0] == 23'h0);
            assign w_is_zero[gi] = (w_ops[gi][30:23] == 8'h00) && (w_ops[gi][22:0] == 23'h0);
            // Denormals carry an effective exponent of 1, not 0
            assign w_exp_adj[gi] = (w_ops[gi][30:23] == 8'h00) ? 8'd1 : w_ops[gi][30:23];
        end
    endgenerate

    logic              w_sign;
    logic signed [9:0] w_exp_sum;

    assign w_sign    = bus.A[31] ^ bus.B[31];
    assign w_exp_sum = $signed({2'b00, w_exp_adj[0]}) + $signed({2'b00, w_exp_adj[1]}) - 10'sd127;

    // ---------------- fix-up priority chain ----------------
    logic [31:0] w_fix_res;
    logic        w_fix_inv;
    logic        w_fix_ovf;
    logic        w_fix_unf;
    logic        w_fix_zero;

    always_comb begin
        w_fix_res = {w_sign, bus.Product[30:0]};
        w_fix_inv = 1'b0;
        w_fix_ovf = 1'b0;
        w_fix_unf = 1'b0;
        if (|w_is_nan) begin
            w_fix_res = 32'h7FC0_0000;
            w_fix_inv = 1'b1;
        end else if ((w_is_inf[0] && w_is_zero[1]) || (w_is_inf[1] && w_is_zero[0])) begin
            w_fix_res = 32'h7FC0_0000;
            w_fix_inv = 1'b1;
        end else if (|w_is_inf) begin
            w_fix_res = {w_sign, 8'hFF, 23'h0};
        end else if (|w_is_zero) begin
            w_fix_res = {w_sign, 31'h0};
        end else if ((w_exp_sum >= 10'sd255) || (bus.Product[30:23] == 8'hFF)) begin
            w_fix_res = {w_sign, 8'hFF, 23'h0};
            w_fix_ovf = 1'b1;
        end else if (w_exp_sum < -10'sd23) begin
            w_fix_res = {w_sign, 31'h0};
            w_fix_unf = 1'b1;
        end
    end

    assign w_fix_zero = (w_fix_res[30:0] == 31'h0);

    // ---------------- FIFO ----------------
    logic [35:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_FW-1:0] r_count;
    logic [CNT_W-1:0]  r_op_count;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_push;
    logic        w_pop;
    logic [35:0] w_head;

    // in_ready depends only on registered occupancy: no pass-through when full
    assign w_in_ready  = (r_count != CNT_FW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_op_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_fix_inv, w_fix_ovf, w_fix_unf, w_fix_zero, w_fix_res};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_op_count      <= r_op_count + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.Result    = w_out_valid ? w_head[31:0] : 32'h0;
    assign bus.Flags     = w_out_valid ? w_head[35:32] : 4'h0;
    assign bus.OpCount   = r_op_count;
endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Directed bench for fp_mul_result_stage: fix-up rules, FIFO backpressure, reset behaviour.
module tb_fp_mul_result_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_mul_result_stage_if #(.CNT_W(16)) bus ();

    fp_mul_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] exp_ops = 16'd0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Product = '0;
        tick(); tick();
        reset = 1'b0;
        exp_ops = 16'd0;
        $display("reset: out_valid=%0b in_ready=%0b Result=%h Flags=%b OpCount=%0d",
                 bus.out_valid, bus.in_ready, bus.Result, bus.Flags, bus.OpCount);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bus.Result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.Result); end
        total++; if (bus.Flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b want=0000", bus.Flags); end
        total++; if (bus.OpCount !== 16'd0) begin bad++; $display("FAIL reset_opcount got=%0d want=0", bus.OpCount); end
    endtask

    task automatic test_normal;
        bus.out_ready = 1'b1;
        bus.A = 32'h3F800000; bus.B = 32'h40000000; bus.Product = 32'h40000000;
        bus.in_valid = 1'b1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL normal_in_ready got=%0b want=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        exp_ops++;
        $display("normal: A=%h B=%h -> Result=%h Flags=%b OpCount=%0d",
                 bus.A, bus.B, bus.Result, bus.Flags, bus.OpCount);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL normal_out_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.Result !== 32'h40000000) begin bad++; $display("FAIL normal_result got=%h want=40000000", bus.Result); end
        total++; if (bus.Flags !== 4'b0000) begin bad++; $display("FAIL normal_flags got=%b want=0000", bus.Flags); end
        total++; if (bus.OpCount !== exp_ops) begin bad++; $display("FAIL normal_opcount got=%0d want=%0d", bus.OpCount, exp_ops); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL normal_drained got=%0b want=0", bus.out_valid); end
        total++; if (bus.Result !== 32'h0) begin bad++; $display("FAIL normal_idle_result got=%h want=0", bus.Result); end
    endtask

    task automatic test_special;
        logic [31:0] va [11];
        logic [31:0] vb [11];
        logic [31:0] vp [11];
        logic [31:0] vr [11];
        logic [3:0]  vf [11];
        va[0]  = 32'h7FC00000; vb[0]  = 32'h3F800000; vp[0]  = 32'h0;        vr[0]  = 32'h7FC00000; vf[0]  = 4'b1000;
        va[1]  = 32'h7F800000; vb[1]  = 32'h80000000; vp[1]  = 32'h0;        vr[1]  = 32'h7FC00000; vf[1]  = 4'b1000;
        va[2]  = 32'hFF800000; vb[2]  = 32'h40000000; vp[2]  = 32'h0;        vr[2]  = 32'hFF800000; vf[2]  = 4'b0000;
        va[3]  = 32'h7F000000; vb[3]  = 32'h7F000000; vp[3]  = 32'h0;        vr[3]  = 32'h7F800000; vf[3]  = 4'b0100;
        va[4]  = 32'h00800000; vb[4]  = 32'h80800000; vp[4]  = 32'h0;        vr[4]  = 32'h80000000; vf[4]  = 4'b0011;
        va[5]  = 32'h80000000; vb[5]  = 32'h40A00000; vp[5]  = 32'h0;        vr[5]  = 32'h80000000; vf[5]  = 4'b0001;
        va[6]  = 32'h3F800000; vb[6]  = 32'h3F800000; vp[6]  = 32'h7F800000; vr[6]  = 32'h7F800000; vf[6]  = 4'b0100;
        va[7]  = 32'h19000000; vb[7]  = 32'h1B000000; vp[7]  = 32'h00400000; vr[7]  = 32'h00400000; vf[7]  = 4'b0000;
        va[8]  = 32'h19000000; vb[8]  = 32'h1A800000; vp[8]  = 32'h00400000; vr[8]  = 32'h00000000; vf[8]  = 4'b0011;
        va[9]  = 32'hBF800000; vb[9]  = 32'h40000000; vp[9]  = 32'h40000000; vr[9]  = 32'hC0000000; vf[9]  = 4'b0000;
        va[10] = 32'h7F800001; vb[10] = 32'h00000000; vp[10] = 32'h0;        vr[10] = 32'h7FC00000; vf[10] = 4'b1000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.A = va[i]; bus.B = vb[i]; bus.Product = vp[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            exp_ops++;
            $display("special[%0d]: A=%h B=%h P=%h -> Result=%h Flags=%b", i, va[i], vb[i], vp[i], bus.Result, bus.Flags);
            total++; if (bus.Result !== vr[i]) begin bad++; $display("FAIL special%0d_result got=%h want=%h", i, bus.Result, vr[i]); end
            total++; if (bus.Flags !== vf[i]) begin bad++; $display("FAIL special%0d_flags got=%b want=%b", i, bus.Flags, vf[i]); end
            total++; if (bus.OpCount !== exp_ops) begin bad++; $display("FAIL special%0d_opcount got=%0d want=%0d", i, bus.OpCount, exp_ops); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000; bus.Product = 32'h40400000; bus.in_valid = 1'b1;
        tick();
        bus.B = 32'h40800000; bus.Product = 32'h40800000;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1 got=%0b want=1", bus.in_ready); end
        tick();
        bus.B = 32'h40A00000; bus.Product = 32'h40A00000;
        $display("bp: two pushed, in_ready=%0b head=%h", bus.in_ready, bus.Result);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.Result !== 32'h40400000) begin bad++; $display("FAIL bp_head_r1 got=%h want=40400000", bus.Result); end
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_ready got=%0b want=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        $display("bp: pop1 head=%h in_ready=%0b OpCount=%0d", bus.Result, bus.in_ready, bus.OpCount);
        total++; if (bus.Result !== 32'h40800000) begin bad++; $display("FAIL bp_head_r2 got=%h want=40800000", bus.Result); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%0b want=1", bus.in_ready); end
        total++; if (bus.OpCount !== exp_ops + 16'd2) begin bad++; $display("FAIL bp_opcount2 got=%0d want=%0d", bus.OpCount, exp_ops + 16'd2); end
        tick();
        bus.in_valid = 1'b0;
        exp_ops = exp_ops + 16'd3;
        $display("bp: pop2 head=%h OpCount=%0d", bus.Result, bus.OpCount);
        total++; if (bus.Result !== 32'h40A00000) begin bad++; $display("FAIL bp_head_r3 got=%h want=40A00000", bus.Result); end
        total++; if (bus.OpCount !== exp_ops) begin bad++; $display("FAIL bp_opcount3 got=%0d want=%0d", bus.OpCount, exp_ops); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_midstream;
        bus.out_ready = 1'b0;
        bus.A = 32'h3F800000; bus.B = 32'h40400000; bus.Product = 32'h40400000;
        bus.in_valid = 1'b1;
        tick(); tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0b want=0", bus.in_ready); end
        // push request kept high across reset: reset must win
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        exp_ops = 16'd0;
        $display("midreset: out_valid=%0b in_ready=%0b Result=%h OpCount=%0d",
                 bus.out_valid, bus.in_ready, bus.Result, bus.OpCount);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bus.OpCount !== 16'd0) begin bad++; $display("FAIL mid_opcount got=%0d want=0", bus.OpCount); end
        total++; if (bus.Result !== 32'h0) begin bad++; $display("FAIL mid_result got=%h want=0", bus.Result); end
        test_normal();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_mul_result_stage.md
Name: fp_mul_result_stage

Overview:
- Registered output stage directly downstream of the combinational single-precision float multiplier in the ALU.
- Takes the multiplier's operands A, B and its raw 32-bit result, and applies IEEE-754 special-case fix-ups that the multiplier does not perform: NaN, infinity, zero, exponent overflow and exponent underflow.
- Buffers the corrected result and status flags in a small FIFO behind a valid/ready handshake.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B and Product are valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- A  input  32  multiplier operand A (IEEE-754 single).
- B  input  32  multiplier operand B.
- Product  input  32  raw multiplier output for the same A and B.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- Result  output  32  corrected product at the FIFO head.
- Flags  output  4  {invalid, overflow, underflow, zero} at the FIFO head.
- OpCount  output  CNT_W  number of accepted operations; wraps.

Behaviour:
- Reset: every state element is cleared on the clock edge while reset=1; reset takes priority over push and pop in the same cycle.
  - After reset: count=0, pointers=0, out_valid=0, in_ready=1, Result=0, Flags=0, OpCount=0.
  - A reset asserted mid-stream discards all buffered entries.
- Handshake:
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH), derived from registered state only; there is no combinational path from out_ready to in_ready.
  - When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - out_valid = (count != 0).
  - Result and Flags show the head entry when out_valid=1, and are 0 otherwise.
- Ordering and latency:
  - Strict FIFO order.
  - An entry pushed into an empty FIFO appears at the outputs on the next cycle (1-cycle latency).
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- OpCount increments by 1 on every push and wraps from 2^CNT_W-1 to 0.
- Fix-up logic (combinational, evaluated at push time, result and flags stored in the entry):
  - Definitions:
    - S = A[31]^B[31].
    - EA = A[30:23], with 0 treated as 1; EB likewise from B[30:23].
    - E = EA + EB - 127, signed 10-bit.
    - Operand is NaN: exp=255 and mant!=0. Inf: exp=255 and mant=0. Zero: exp=0 and mant=0.
  - Priority, highest first:
    1. Either operand NaN -> 32'h7FC00000; invalid=1.
    2. One operand Inf and the other Zero -> 32'h7FC00000; invalid=1.
    3. Either operand Inf -> {S, 8'hFF, 23'h0}; overflow=0.
    4. Either operand Zero -> {S, 31'h0}.
    5. E >= 255, or Product[30:23]==8'hFF -> {S, 8'hFF, 23'h0}; overflow=1.
    6. E < -23 -> {S, 31'h0}; underflow=1.
    7. Otherwise -> {S, Product[30:0]}.
  - After the rule is applied: zero=1 iff Result[30:0]==0. Flags not set by the rule are 0.

Test Plan:
- Normal product, DEPTH=2, out_ready=1: push A=3F800000, B=40000000, Product=40000000 -> one cycle later out_valid=1, Result=40000000, Flags=0000; OpCount=1.
- NaN and invalid cases:
  - A=7FC00000, B=3F800000 -> Result=7FC00000, Flags=1000.
  - A=7F800000, B=80000000 -> Result=7FC00000, Flags=1000.
- Infinity and overflow:
  - A=FF800000, B=40000000 -> Result=FF800000, Flags=0000.
  - A=7F000000, B=7F000000 (E=381) -> Result=7F800000, Flags=0100.
- Underflow: A=00800000, B=80800000 (E=-125) -> Result=80000000, Flags=0011.
- Full/backpressure, DEPTH=2, out_ready=0, three consecutive pushes of results R1, R2, R3:
  - in_ready drops after the 2nd push; the 3rd push is held.
  - Raising out_ready drains R1 then R2; R3 is accepted in the cycle after the first pop.
  - Output order is R1, R2, R3; OpCount=3.
- Reset mid-stream with 2 entries buffered: reset=1 for one cycle -> out_valid=0, in_ready=1, OpCount=0, Result=0 on the next cycle; a subsequent push behaves as in the normal-product case.
